// File: rtl/timer_irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_irq_pkg                                                        |
// | Register map, CTRL field positions, mode codes and FSM encoding.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package timer_irq_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_W        = 4;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Only the reload code auto-reloads; every other mode value is one-shot.
  function automatic logic is_reload(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_irq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_irq                                                            |
// | Memory-mapped down-counter timer with one-shot / auto-reload IRQ.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter int              CNT_W      = 32,
  parameter logic [CNT_W-1:0] RST_PRESET = '0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [1:0]        r_state;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_preset;
  logic [CNT_W-1:0]  r_count;
  logic              r_irq_flag;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_ack;
  logic w_expire;
  logic w_hw_clr_en;
  logic w_reload_clr;
  logic w_unused;

  assign w_wr_ctrl   = We && (Addr == ADDR_CTRL);
  assign w_wr_preset = We && (Addr == ADDR_PRESET);
  assign w_ack       = w_wr_ctrl || w_wr_preset;

  assign w_expire     = (r_state == ST_CNT) && r_ctrl[CTRL_EN] && !(r_count > c_one);
  assign w_hw_clr_en  = (r_state == ST_INT) && !is_reload(r_ctrl);
  assign w_reload_clr = (r_state == ST_INT) &&  is_reload(r_ctrl);

  assign w_unused = ^Din;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (r_ctrl[CTRL_EN]) r_state <= ST_LOAD;
        ST_LOAD: r_state <= ST_CNT;
        ST_CNT: begin
          if (!r_ctrl[CTRL_EN]) r_state <= ST_IDLE;
          else if (w_expire)    r_state <= ST_INT;
        end
        ST_INT:  r_state <= is_reload(r_ctrl) ? ST_LOAD : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_count <= '0;
    end else if (r_state == ST_LOAD) begin
      r_count <= r_preset;
    end else if (r_state == ST_CNT && r_ctrl[CTRL_EN]) begin
      // Clamp at zero so a PRESET of 0 or 1 never wraps the counter.
      r_count <= w_expire ? '0 : r_count - c_one;
    end
  end

  // A software write in the same cycle as the hardware En clear takes priority.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ctrl <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= Din[CTRL_W-1:0];
    end else if (w_hw_clr_en) begin
      r_ctrl[CTRL_EN] <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_preset <= RST_PRESET;
    end else if (w_wr_preset) begin
      r_preset <= Din[CNT_W-1:0];
    end
  end

  // Acknowledge beats a simultaneous expiry.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_irq_flag <= 1'b0;
    end else if (w_ack || w_reload_clr) begin
      r_irq_flag <= 1'b0;
    end else if (w_expire) begin
      r_irq_flag <= 1'b1;
    end
  end

  assign IRQ = r_irq_flag & r_ctrl[CTRL_IM];

  always_comb begin
    Dout = '0;
    case (Addr)
      ADDR_CTRL:   Dout = {{(32-CTRL_W){1'b0}}, r_ctrl};
      ADDR_PRESET: Dout = 32'(r_preset);
      ADDR_COUNT:  Dout = 32'(r_count);
      default:     Dout = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_irq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_timer_irq                                                         |
// | Directed and random bench for timer_irq against a timeline model.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_timer_irq;

  localparam int CNT_W = 8;

  logic        Clk;
  logic        Rst_n;
  logic [1:0]  Addr;
  logic        We;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_tests;
  int n_fail;

  timer_irq #(.CNT_W(CNT_W), .RST_PRESET(8'd0)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Addr  (Addr),
    .We    (We),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: a run is described by its load time and length; COUNT
  // is derived arithmetically from elapsed time rather than stepped down.
  typedef enum {M_IDLE, M_ARMED, M_RUNNING, M_FIRED} mph_t;
  mph_t       m_ph;
  logic [3:0] m_ctrl;
  logic [7:0] m_preset;
  logic [7:0] m_count;
  bit         m_flag;
  int         cyc;
  int         run_start;
  int         run_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 0;
    cyc = 0; run_start = 0; run_len = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'b0, m_ctrl};
      2'd1:    return {24'b0, m_preset};
      2'd2:    return {24'b0, m_count};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input bit we, input logic [1:0] a, input logic [31:0] d);
    int len_eff;
    case (m_ph)
      M_IDLE: if (m_ctrl[0]) m_ph = M_ARMED;
      M_ARMED: begin
        run_start = cyc; run_len = int'(m_preset); m_count = m_preset; m_ph = M_RUNNING;
      end
      M_RUNNING: begin
        len_eff = (run_len == 0) ? 1 : run_len;
        if (!m_ctrl[0]) m_ph = M_IDLE;
        else if (cyc - run_start >= len_eff) begin
          m_count = '0; m_flag = 1; m_ph = M_FIRED;
        end else m_count = 8'(run_len - (cyc - run_start));
      end
      M_FIRED: begin
        if (m_ctrl[2:1] == 2'b01) begin m_flag = 0; m_ph = M_ARMED; end
        else begin m_ctrl[0] = 1'b0; m_ph = M_IDLE; end
      end
      default: m_ph = M_IDLE;
    endcase
    if (we && a == 2'd0) m_ctrl = d[3:0];
    if (we && a == 2'd1) m_preset = d[7:0];
    if (we && a <= 2'd1) m_flag = 0;
    cyc++;
  endtask

  // One clock: drive at the falling edge, update model at the rising edge,
  // compare IRQ and read data at the next falling edge.
  task automatic tick(input bit we, input logic [1:0] a, input logic [31:0] d);
    We = we; Addr = a; Din = d;
    @(posedge Clk);
    model_step(we, a, d);
    @(negedge Clk);
    We = 1'b0;
    check("irq", {31'b0, IRQ}, {31'b0, m_flag & m_ctrl[3]});
    check("dout", Dout, model_read(a));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    tick(1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    tick(1'b0, a, 32'd0);
  endtask

  task automatic quiesce();
    wr(2'd0, 32'd0);
    for (int k = 0; k < 4; k++) rd(2'd2);
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 4; k++) begin
      Addr = 2'(k);
      #1;
      check(tag, Dout, 32'd0);
    end
    check({tag, "_irq"}, {31'b0, IRQ}, 32'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    Rst_n = 1'b0; We = 1'b0; Addr = 2'd0; Din = '0;
    model_reset();
    @(negedge Clk); @(negedge Clk);
    check_all_zero("reset");
    @(negedge Clk);
    Rst_n = 1'b1;

    // One-shot, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int i = 1; i <= 7; i++) begin
      rd(2'd2);
      if (i == 2) check("os_cnt_e2", Dout, 32'd5);
      if (i == 6) check("os_irq_e6", {31'b0, IRQ}, 32'd0);
      if (i == 7) begin
        check("os_cnt_e7", Dout, 32'd0);
        check("os_irq_e7", {31'b0, IRQ}, 32'd1);
      end
    end
    rd(2'd0);
    check("os_ctrl", Dout, 32'h8);
    check("os_irq_hold", {31'b0, IRQ}, 32'd1);
    wr(2'd0, 32'h8);
    check("os_ack", {31'b0, IRQ}, 32'd0);

    // Auto-reload, PRESET=3: pulses every 5 cycles
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int i = 1; i <= 22; i++) begin
      rd(2'd2);
      check("ar_pulse", {31'b0, IRQ}, {31'b0, (i >= 5 && i % 5 == 0)});
      case (i)
        2: check("ar_cnt2", Dout, 32'd3);
        3: check("ar_cnt3", Dout, 32'd2);
        4: check("ar_cnt4", Dout, 32'd1);
        5: check("ar_cnt5", Dout, 32'd0);
        6: check("ar_cnt6", Dout, 32'd0);
        7: check("ar_cnt7", Dout, 32'd3);
        default: ;
      endcase
    end
    quiesce();

    // Mask: flag sets silently, CTRL write acknowledges it
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int i = 1; i <= 6; i++) begin
      rd(2'd2);
      check("mask_irq", {31'b0, IRQ}, 32'd0);
    end
    wr(2'd0, 32'h8);
    rd(2'd0);
    check("mask_ack", {31'b0, IRQ}, 32'd0);
    // IM set while the count is still pending
    wr(2'd0, 32'h1);
    rd(2'd2);
    wr(2'd0, 32'h9);
    rd(2'd2);
    check("im_late_e3", {31'b0, IRQ}, 32'd0);
    rd(2'd2);
    check("im_late_e4", {31'b0, IRQ}, 32'd1);
    wr(2'd0, 32'h8);
    check("im_late_ack", {31'b0, IRQ}, 32'd0);

    // Pause at 6, then reload from a new PRESET
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int i = 1; i <= 5; i++) rd(2'd2);
    check("pause_cnt7", Dout, 32'd7);
    wr(2'd0, 32'h8);
    for (int i = 0; i < 3; i++) begin
      rd(2'd2);
      check("pause_hold", Dout, 32'd6);
    end
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    for (int i = 1; i <= 6; i++) begin
      rd(2'd2);
      if (i == 2) check("resume_cnt", Dout, 32'd4);
      if (i == 5) check("resume_irq_e5", {31'b0, IRQ}, 32'd0);
      if (i == 6) check("resume_irq_e6", {31'b0, IRQ}, 32'd1);
    end
    wr(2'd0, 32'h8);

    // Async reset while COUNT=7
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int i = 1; i <= 5; i++) rd(2'd2);
    check("rst_pre_cnt", Dout, 32'd7);
    #2 Rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    rd(2'd2);

    // PRESET=0 one-shot expires on E3
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    rd(2'd2);
    rd(2'd2);
    check("p0_cnt_e2", Dout, 32'd0);
    check("p0_irq_e2", {31'b0, IRQ}, 32'd0);
    rd(2'd2);
    check("p0_irq_e3", {31'b0, IRQ}, 32'd1);
    wr(2'd0, 32'h8);

    // CTRL write on the INT edge: software value wins, flag acked
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    for (int i = 1; i <= 4; i++) rd(2'd2);
    check("sw_irq_e4", {31'b0, IRQ}, 32'd1);
    wr(2'd0, 32'h9);
    check("sw_ctrl", Dout, 32'h9);
    check("sw_irq", {31'b0, IRQ}, 32'd0);
    quiesce();

    // Reserved / read-only addresses ignore writes
    wr(2'd2, 32'hFF);
    rd(2'd2);
    check("ro_cnt", Dout, 32'd2);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd0);
    check("ro_ctrl", Dout, 32'd0);
    rd(2'd1);
    check("ro_preset", Dout, 32'd2);
    rd(2'd3);
    check("ro_rsvd", Dout, 32'd0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      bit          w;
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 5) == 0);
      d = $urandom;
      if (a == 2'd1) d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
      tick(w, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
